// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   state_t      - processor run state (RUN / WAITING / HALTED)
//   BR_*         - Tipo_Branch codes produced by the decoder
//   branch_taken - condition evaluation for a Tipo_Branch code and ALU flags
package pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAITING = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_RSV  = 3'd5;
    localparam logic [2:0] BR_JAL  = 3'd6;
    localparam logic [2:0] BR_JR   = 3'd7;

    // Codes 0 and 5 are never taken.
    function automatic logic branch_taken(input logic [2:0] tipo,
                                          input logic       zero,
                                          input logic       neg);
        logic t;
        t = 1'b0;
        case (tipo)
            BR_BEQ:        t = zero;
            BR_BNE:        t = ~zero;
            BR_BLT:        t = neg;
            BR_BGE:        t = ~neg;
            BR_JAL, BR_JR: t = 1'b1;
            default:       t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/contador_quantum.sv
// contador_quantum: preemption quantum counter.
//   clk, reset - clock, synchronous active-high reset
//   en         - count one user instruction
//   clr        - restart the quantum (wins over en)
//   expira     - counter is at QUANTUM-1: the current user instruction is
//                the last one of the quantum
module contador_quantum
    import pc_pkg::*;
#(
    parameter int unsigned QUANTUM = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expira
);

    localparam int unsigned CNT_W = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expira = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            // Wrap keeps the counter in range even if the owner does not clear it.
            count_d = expira ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sequenciador_pc.sv
// sequenciador_pc: program-counter sequencer.
// Selects the next instruction address from decoded control strobes and ALU
// flags, owns the run state (RUN/WAITING/HALTED), user/OS mode and the
// quantum-based preemption that returns control to the OS.
//   clk, reset                 - clock, synchronous active-high reset
//   PCSrc, Tipo_Branch         - control-flow instruction and its kind
//   zero, neg                  - ALU flags for conditional branches
//   imm                        - signed PC-relative offset
//   rs2_val                    - absolute target for type-7 / jr_ctx / jr_so
//   HALT, WAIT                 - stop / wait-for-continuar strobes
//   Set_ctx, Set_pid_0         - jump into user process / into OS
//   Check_preemp               - read-and-clear of preemp_flag
//   continuar                  - resume pulse, only meaningful in WAITING
//   pc, pc_mais1               - current address and its link value
//   ctx_pc                     - address to resume the preempted process
//   preemp_flag                - sticky preemption indicator
//   modo_usuario               - 1 while a user process runs
//   halted, waiting, exec_en   - state indicators; exec_en only in RUN
module sequenciador_pc
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned QUANTUM  = 64,
    parameter int unsigned SO_ENTRY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrc,
    input  logic [2:0]        Tipo_Branch,
    input  logic              zero,
    input  logic              neg,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs2_val,
    input  logic              HALT,
    input  logic              WAIT,
    input  logic              Set_ctx,
    input  logic              Set_pid_0,
    input  logic              Check_preemp,
    input  logic              continuar,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_mais1,
    output logic [ADDR_W-1:0] ctx_pc,
    output logic              preemp_flag,
    output logic              modo_usuario,
    output logic              halted,
    output logic              waiting,
    output logic              exec_en
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ctx_pc_q, ctx_pc_d;
    logic              flag_q, flag_d;
    logic              modo_q, modo_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_normal;
    logic              taken;
    logic              issue;
    logic              ctx_jump;
    logic              preempt;
    logic              expira;
    logic              cnt_en;
    logic              cnt_clr;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign taken  = PCSrc & branch_taken(Tipo_Branch, zero, neg);

    always_comb begin
        pc_normal = pc_inc;
        if (taken) begin
            pc_normal = (Tipo_Branch == BR_JR) ? rs2_val : pc_q + imm;
        end
    end

    // An instruction completes this cycle: RUN and not stalling on HALT/WAIT.
    assign issue    = (state_q == ST_RUN) & ~HALT & ~WAIT;
    assign ctx_jump = issue & (Set_ctx | Set_pid_0);
    assign preempt  = issue & modo_q & expira & ~Set_ctx & ~Set_pid_0;
    assign cnt_en   = issue & modo_q;
    assign cnt_clr  = ctx_jump | preempt;

    contador_quantum #(
        .QUANTUM(QUANTUM)
    ) u_quantum (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .expira(expira)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ctx_pc_d = ctx_pc_q;
        flag_d   = flag_q;
        modo_d   = modo_q;
        case (state_q)
            ST_RUN: begin
                if (HALT) begin
                    state_d = ST_HALTED;
                end else if (WAIT) begin
                    state_d = ST_WAITING;
                end else if (Set_ctx) begin
                    pc_d   = rs2_val;
                    modo_d = 1'b1;
                end else if (Set_pid_0) begin
                    pc_d   = rs2_val;
                    modo_d = 1'b0;
                end else if (preempt) begin
                    ctx_pc_d = pc_normal;
                    pc_d     = ADDR_W'(SO_ENTRY);
                    modo_d   = 1'b0;
                end else begin
                    pc_d = pc_normal;
                end
                // Set is evaluated after clear so a coincident preemption wins.
                if (Check_preemp) begin
                    flag_d = 1'b0;
                end
                if (preempt) begin
                    flag_d = 1'b1;
                end
            end
            ST_WAITING: begin
                if (continuar) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            ctx_pc_q <= '0;
            flag_q   <= 1'b0;
            modo_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ctx_pc_q <= ctx_pc_d;
            flag_q   <= flag_d;
            modo_q   <= modo_d;
        end
    end

    assign pc           = pc_q;
    assign pc_mais1     = pc_inc;
    assign ctx_pc       = ctx_pc_q;
    assign preemp_flag  = flag_q;
    assign modo_usuario = modo_q;
    assign halted       = (state_q == ST_HALTED);
    assign waiting      = (state_q == ST_WAITING);
    assign exec_en      = (state_q == ST_RUN);

endmodule

// File: tb/tb_sequenciador_pc.sv
// Testbench for sequenciador_pc: directed vector table, a hand-written
// combinational-visibility sequence, then randomized stimulus against a
// reference model of the sequencer rules.
module tb_sequenciador_pc;

    localparam int AW  = 10;
    localparam int M   = 1 << AW;
    localparam int Q   = 4;
    localparam int SO  = 0;

    logic          clk;
    logic          reset;
    logic          PCSrc;
    logic [2:0]    Tipo_Branch;
    logic          zero;
    logic          neg;
    logic [AW-1:0] imm;
    logic [AW-1:0] rs2_val;
    logic          HALT;
    logic          WAIT;
    logic          Set_ctx;
    logic          Set_pid_0;
    logic          Check_preemp;
    logic          continuar;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_mais1;
    logic [AW-1:0] ctx_pc;
    logic          preemp_flag;
    logic          modo_usuario;
    logic          halted;
    logic          waiting;
    logic          exec_en;

    sequenciador_pc #(
        .ADDR_W  (AW),
        .QUANTUM (Q),
        .SO_ENTRY(SO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .Tipo_Branch (Tipo_Branch),
        .zero        (zero),
        .neg         (neg),
        .imm         (imm),
        .rs2_val     (rs2_val),
        .HALT        (HALT),
        .WAIT        (WAIT),
        .Set_ctx     (Set_ctx),
        .Set_pid_0   (Set_pid_0),
        .Check_preemp(Check_preemp),
        .continuar   (continuar),
        .pc          (pc),
        .pc_mais1    (pc_mais1),
        .ctx_pc      (ctx_pc),
        .preemp_flag (preemp_flag),
        .modo_usuario(modo_usuario),
        .halted      (halted),
        .waiting     (waiting),
        .exec_en     (exec_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {OP_NOP, OP_RST, OP_BR, OP_JR, OP_CTX, OP_PID,
                      OP_HALT, OP_WAIT, OP_CHK, OP_CONT} op_t;

    typedef struct {
        op_t           op;
        logic [2:0]    tipo;
        logic          z;
        logic [AW-1:0] im;
        logic [AW-1:0] r2;
        int            rep;
        int            e_pc;
        int            e_ctx;
        int            e_modo;
        int            e_flag;
        int            e_halt;
        int            e_wait;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vec(op_t op, int tipo, int z, int im, int r2, int rep,
                                 int e_pc, int e_ctx, int e_modo, int e_flag,
                                 int e_halt, int e_wait);
        vec_t v;
        v.op = op; v.tipo = 3'(tipo); v.z = 1'(z); v.im = AW'(im); v.r2 = AW'(r2);
        v.rep = rep; v.e_pc = e_pc; v.e_ctx = e_ctx; v.e_modo = e_modo;
        v.e_flag = e_flag; v.e_halt = e_halt; v.e_wait = e_wait;
        return v;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_pc, input int e_ctx,
                             input int e_modo, input int e_flag,
                             input int e_halt, input int e_wait);
        cmp({tag, ".pc"}, int'(pc), e_pc);
        cmp({tag, ".pc_mais1"}, int'(pc_mais1), (e_pc + 1) % M);
        cmp({tag, ".ctx_pc"}, int'(ctx_pc), e_ctx);
        cmp({tag, ".modo"}, int'(modo_usuario), e_modo);
        cmp({tag, ".flag"}, int'(preemp_flag), e_flag);
        cmp({tag, ".halted"}, int'(halted), e_halt);
        cmp({tag, ".waiting"}, int'(waiting), e_wait);
        cmp({tag, ".exec_en"}, int'(exec_en), (e_halt == 0 && e_wait == 0) ? 1 : 0);
    endtask

    task automatic drive(input op_t op, input logic [2:0] t, input logic z,
                         input logic [AW-1:0] im, input logic [AW-1:0] r2);
        reset = 1'b0; PCSrc = 1'b0; Tipo_Branch = 3'd0; zero = z; neg = 1'b0;
        imm = im; rs2_val = r2; HALT = 1'b0; WAIT = 1'b0; Set_ctx = 1'b0;
        Set_pid_0 = 1'b0; Check_preemp = 1'b0; continuar = 1'b0;
        case (op)
            OP_RST:  reset = 1'b1;
            OP_BR:   begin PCSrc = 1'b1; Tipo_Branch = t; end
            OP_JR:   begin PCSrc = 1'b1; Tipo_Branch = 3'd7; end
            OP_CTX:  begin PCSrc = 1'b1; Tipo_Branch = 3'd7; Set_ctx = 1'b1; end
            OP_PID:  begin PCSrc = 1'b1; Tipo_Branch = 3'd7; Set_pid_0 = 1'b1; end
            OP_HALT: HALT = 1'b1;
            OP_WAIT: WAIT = 1'b1;
            OP_CHK:  Check_preemp = 1'b1;
            OP_CONT: continuar = 1'b1;
            default: ;
        endcase
    endtask

    // Reference model: plain integers, updated from the inputs present at an edge.
    int m_st;      // 0 RUN, 1 WAITING, 2 HALTED
    int m_pc, m_ctx, m_flag, m_mode, m_used;

    task automatic model_step();
        int  nxt;
        bit  tk;
        if (reset) begin
            m_st = 0; m_pc = 0; m_ctx = 0; m_flag = 0; m_mode = 0; m_used = 0;
        end else if (m_st == 2) begin
            m_st = 2;
        end else if (m_st == 1) begin
            if (continuar) begin m_pc = (m_pc + 1) % M; m_st = 0; end
        end else if (HALT) begin
            m_st = 2;
        end else if (WAIT) begin
            m_st = 1;
        end else begin
            case (int'(Tipo_Branch))
                1: tk = zero;
                2: tk = !zero;
                3: tk = neg;
                4: tk = !neg;
                6, 7: tk = 1;
                default: tk = 0;
            endcase
            tk = tk && PCSrc;
            if (!tk) nxt = (m_pc + 1) % M;
            else if (Tipo_Branch == 3'd7) nxt = int'(rs2_val);
            else nxt = (m_pc + int'(imm)) % M;
            if (Check_preemp) m_flag = 0;
            if (Set_ctx) begin
                m_pc = int'(rs2_val); m_mode = 1; m_used = 0;
            end else if (Set_pid_0) begin
                m_pc = int'(rs2_val); m_mode = 0; m_used = 0;
            end else if (m_mode == 1 && m_used == Q - 1) begin
                m_ctx = nxt; m_pc = SO; m_mode = 0; m_flag = 1; m_used = 0;
            end else begin
                m_pc = nxt;
                if (m_mode == 1) m_used++;
            end
        end
    endtask

    initial begin
        drive(OP_RST, 3'd0, 1'b0, '0, '0);

        // Directed table, QUANTUM = 4.
        tbl.push_back(vec(OP_RST, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(vec(OP_NOP, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_JR,   0, 0,  0,  10, 1,  10, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_BR,   1, 1, -4,   0, 1,   6, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_JR,   0, 0,  0,  10, 1,  10, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_BR,   1, 0, -4,   0, 1,  11, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_JR,   0, 0,  0, 200, 1, 200, 0, 0, 0, 0, 0));
        // Quantum expiry from straight-line user code.
        tbl.push_back(vec(OP_CTX,  0, 0,  0, 100, 1, 100, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 101, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 102, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 103, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1,   0, 104, 0, 1, 0, 0));
        tbl.push_back(vec(OP_CHK,  0, 0,  0,   0, 1,   1, 104, 0, 0, 0, 0));
        // WAIT mid-quantum: counter holds while waiting.
        tbl.push_back(vec(OP_CTX,  0, 0,  0, 300, 1, 300, 104, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 301, 104, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 302, 104, 1, 0, 0, 0));
        tbl.push_back(vec(OP_WAIT, 0, 0,  0,   0, 1, 302, 104, 1, 0, 0, 1));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 10, 302, 104, 1, 0, 0, 1));
        tbl.push_back(vec(OP_CONT, 0, 0,  0,   0, 1, 303, 104, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 304, 104, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1,   0, 305, 0, 1, 0, 0));
        tbl.push_back(vec(OP_CHK,  0, 0,  0,   0, 1,   1, 305, 0, 0, 0, 0));
        // HALT is absorbing, continuar ignored, reset exits.
        tbl.push_back(vec(OP_JR,   0, 0,  0,   7, 1,   7, 305, 0, 0, 0, 0));
        tbl.push_back(vec(OP_HALT, 0, 0,  0,   0, 1,   7, 305, 0, 0, 1, 0));
        tbl.push_back(vec(OP_CONT, 0, 0,  0,   0, 20,  7, 305, 0, 0, 1, 0));
        tbl.push_back(vec(OP_RST,  0, 0,  0,   0, 1,   0, 0, 0, 0, 0, 0));
        // Address wrap.
        tbl.push_back(vec(OP_JR,   0, 0,  0, 1023, 1, 1023, 0, 0, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1,   0, 0, 0, 0, 0, 0));
        // Expiry coincident with Set_pid_0: jump wins, no preemption.
        tbl.push_back(vec(OP_CTX,  0, 0,  0, 500, 1, 500, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 501, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 502, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 503, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_PID,  0, 0,  0,  50, 1,  50, 0, 0, 0, 0, 0));
        // Expiry coincident with Check_preemp: set wins.
        tbl.push_back(vec(OP_CTX,  0, 0,  0, 600, 1, 600, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 601, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 602, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_NOP,  0, 0,  0,   0, 1, 603, 0, 1, 0, 0, 0));
        tbl.push_back(vec(OP_CHK,  0, 0,  0,   0, 1,   0, 604, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                @(negedge clk);
                drive(tbl[i].op, tbl[i].tipo, tbl[i].z, tbl[i].im, tbl[i].r2);
                @(posedge clk);
                #1;
                check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_ctx,
                          tbl[i].e_modo, tbl[i].e_flag, tbl[i].e_halt, tbl[i].e_wait);
            end
        end

        // Flag is readable while Check_preemp is asserted, then clears at the edge.
        @(negedge clk);
        drive(OP_CHK, 3'd0, 1'b0, '0, '0);
        #1;
        cmp("chk_visible.flag", int'(preemp_flag), 1);
        @(posedge clk);
        #1;
        cmp("chk_cleared.flag", int'(preemp_flag), 0);
        cmp("chk_cleared.pc", int'(pc), 1);

        // Randomized run against the reference model.
        @(negedge clk);
        drive(OP_RST, 3'd0, 1'b0, '0, '0);
        model_step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 4000; n++) begin
            int r;
            @(negedge clk);
            drive(OP_NOP, 3'd0, 1'b0, '0, '0);
            r = int'($urandom_range(0, 999));
            reset       = (r < 3) || (m_st == 2 && $urandom_range(0, 9) == 0);
            HALT        = (r >= 3 && r < 6);
            WAIT        = (r >= 6 && r < 40);
            PCSrc       = 1'($urandom_range(0, 1));
            Tipo_Branch = 3'($urandom_range(0, 7));
            zero        = 1'($urandom_range(0, 1));
            neg         = 1'($urandom_range(0, 1));
            imm         = AW'(int'($urandom_range(0, 31)) - 16);
            rs2_val     = AW'($urandom);
            continuar   = ($urandom_range(0, 3) == 0);
            if (!HALT && !WAIT) begin
                Set_ctx      = ($urandom_range(0, 19) == 0);
                Set_pid_0    = !Set_ctx && ($urandom_range(0, 29) == 0);
                Check_preemp = ($urandom_range(0, 7) == 0);
            end
            model_step();
            @(posedge clk);
            #1;
            check_all($sformatf("rnd%0d", n), m_pc, m_ctx, m_mode, m_flag,
                      (m_st == 2) ? 1 : 0, (m_st == 1) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
